ext_arbiter: RTL and testbench
==============================

// Module: ext_arbiter
// PURPOSE
//   Shares one immediate extender among N_REQ requesters (decode lanes, debug port, etc.).
//   Each requester offers {imm, EOp} over a valid/ready handshake.
//   A round-robin arbiter grants one request per cycle and feeds it to the shared ext
//   datapath. The 32-bit result is registered and returned with the requester id over
//   an output valid/ready handshake.
// PARAMETERS
//   N_REQ  4  number of requesters (2..8)
//   ID_W   2  width of requester id, = clog2(N_REQ)
// PORTS
//   clk        in   1         system clock, rising edge
//   reset_n    in   1         asynchronous, active-low reset
//   req_valid  in   N_REQ     request i present
//   req_imm    in   16*N_REQ  imm of requester i in bits [16i+15:16i]
//   req_eop    in   2*N_REQ   EOp of requester i in bits [2i+1:2i]
//   req_ready  out  N_REQ     one-hot grant; request i consumed when valid[i]&ready[i]
//   out_valid  out  1         out_ext/out_id hold a result
//   out_ext    out  32        extended immediate
//   out_id     out  ID_W      index of requester that produced out_ext
//   out_ready  in   1         consumer accepts result this cycle
// BEHAVIOUR
//   Reset (async assert, sync release): out_valid=0, out_ext=0, out_id=0, rr_ptr=0.
//     req_ready is forced to 0 while reset_n=0.
//   EOp encoding, applied to the granted imm:
//     00 = sign-ext
//     01 = zero-ext
//     10 = imm<<16 (low half 0)
//     11 = sign-ext then <<2
//   can_load = !out_valid | out_ready (the output register is empty or drains this cycle).
//   Grant (combinational):
//     - if can_load, grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ...
//       mod N_REQ;
//     - req_ready = onehot(grant); all zeros if !can_load or no request is valid.
//   req_ready never depends on out_ready through a path of more than one gate level
//     (can_load only).
//   On a handshake with granted index g:
//     - out_ext <= ext(imm[g], eop[g]); out_id <= g; out_valid <= 1;
//     - rr_ptr <= (g+1) mod N_REQ.
//   No handshake and out_ready: out_valid <= 0. rr_ptr is unchanged whenever no grant occurs.
//   Latency: request accepted in cycle T -> out_valid=1 with the result in cycle T+1.
//     Throughput: 1 result/cycle when out_ready is held high.
//   Backpressure: while out_valid & !out_ready, out_ext/out_id/out_valid hold and all
//     req_ready=0.
//   Simultaneous drain+load in the same cycle (out_valid, out_ready, new grant): the
//     register is overwritten; no bubble.
//   Fairness: a continuously valid requester is granted within N_REQ grants.
//   Wrap-around: g = N_REQ-1 gives rr_ptr = 0.
//   Requester rules:
//     - a requester must hold imm/eop stable while valid and not ready;
//     - the block does not check this;
//     - dropping valid before grant is allowed and loses nothing.
//   Reset mid-operation: a pending out_valid is discarded; any request in flight is
//     lost (the requester re-presents it after reset).
// STRUCTURE
//   Shared package ext_pkg:
//     - EOP_SIGN=2'b00, EOP_ZERO=2'b01, EOP_LUI=2'b10, EOP_SIGN_SH2=2'b11;
//     - EXT_W=32, IMM_W=16.
//   One sub-module: rr_arbiter
//     - parameter N;
//     - inputs: req vector, rr_ptr, enable;
//     - output: one-hot grant plus encoded index;
//     - purely combinational.
//   The ext datapath is the existing extender instantiated once on the muxed imm/eop.
//   The top level holds only the output register, rr_ptr and the mux.
// TESTING
//   1 Reset: reset_n=0 with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_ext=0;
//     release -> first grant goes to req 0.
//   2 EOp coverage, single requester 2, imm=16'h8001, out_ready=1:
//     - eop 00 -> 32'hFFFF8001
//     - eop 01 -> 32'h00008001
//     - eop 10 -> 32'h80010000
//     - eop 11 -> 32'hFFFE0004
//     - all with out_id=2, one cycle after grant.
//   3 Round-robin: all 4 valid, out_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3;
//     one result per cycle.
//   4 Backpressure: out_ready=0 for 3 cycles with result pending -> out_* stable,
//     req_ready=0; out_ready=1 -> the next grant loads in the same cycle.
//   5 Pointer skip/wrap: rr_ptr=3, only req 1 valid -> grant 1, rr_ptr becomes 2;
//     then only req 3 then req 0 valid -> rr_ptr goes 0, then 1.
//   6 Reset mid-operation: assert reset_n=0 asynchronously while out_valid=1 ->
//     out_valid drops immediately with no clock; rr_ptr=0 after release.

Source files
------------

// File: rtl/ext_pkg.sv
// ============================================================================
//  Module      : ext_pkg
//  Description : Shared types, widths and the immediate extender function.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ext_pkg;

    localparam int EXT_W = 32;
    localparam int IMM_W = 16;

    typedef enum logic [1:0] {
        EOP_SIGN     = 2'b00,
        EOP_ZERO     = 2'b01,
        EOP_LUI      = 2'b10,
        EOP_SIGN_SH2 = 2'b11
    } eop_e;

    function automatic logic [EXT_W-1:0] ext_apply(input logic [IMM_W-1:0] imm,
                                                   input logic [1:0]       eop);
        logic [EXT_W-1:0] result;
        case (eop_e'(eop))
            EOP_SIGN:     result = {{(EXT_W-IMM_W){imm[IMM_W-1]}}, imm};
            EOP_ZERO:     result = {{(EXT_W-IMM_W){1'b0}}, imm};
            EOP_LUI:      result = {imm, {(EXT_W-IMM_W){1'b0}}};
            EOP_SIGN_SH2: result = {{(EXT_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
            default:      result = '0;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ext_arbiter_if.sv
// ============================================================================
//  Module      : ext_arbiter_if
//  Description : Request and result handshake bundle of the shared extender.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ext_arbiter_if
    import ext_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0]       req_valid;
    logic [IMM_W*N_REQ-1:0] req_imm;
    logic [2*N_REQ-1:0]     req_eop;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [EXT_W-1:0]       out_ext;
    logic [ID_W-1:0]        out_id;
    logic                   out_ready;

    // Requesters and result consumer
    modport master (
        output req_valid, req_imm, req_eop, out_ready,
        input  req_ready, out_valid, out_ext, out_id
    );

    // Arbitrated extender
    modport slave (
        input  req_valid, req_imm, req_eop, out_ready,
        output req_ready, out_valid, out_ext, out_id
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter, scan starts at rr_ptr.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] rr_ptr,
    input  wire logic             enable,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] grant_idx
);

    logic found;

    always_comb begin
        int j;
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        j         = 0;
        // Rotated priority: rr_ptr first, wrapping modulo N
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ext_arbiter.sv
// ============================================================================
//  Module      : ext_arbiter
//  Description : Round-robin shares one immediate extender among N_REQ requesters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_arbiter
    import ext_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    ext_arbiter_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [EXT_W-1:0] out_ext_q,   out_ext_d;
    logic [ID_W-1:0]  out_id_q,    out_id_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             can_load;
    logic             arb_en;
    logic             handshake;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [IMM_W-1:0] sel_imm;
    logic [1:0]       sel_eop;
    logic [EXT_W-1:0] sel_ext;

    // reset_n gates the grant so req_ready is low throughout reset
    assign can_load = !out_valid_q || bus.out_ready;
    assign arb_en   = can_load && reset_n;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (arb_en),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign handshake     = |gnt;
    assign bus.req_ready = gnt;

    assign sel_imm = bus.req_imm[gnt_idx*IMM_W +: IMM_W];
    assign sel_eop = bus.req_eop[gnt_idx*2 +: 2];
    assign sel_ext = ext_apply(sel_imm, sel_eop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_ext_q   <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ext_q   <= out_ext_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ext_d   = out_ext_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        // A new grant overwrites a draining result in the same cycle
        if (handshake) begin
            out_valid_d = 1'b1;
            out_ext_d   = sel_ext;
            out_id_d    = gnt_idx;
            rr_ptr_d    = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_ext   = out_ext_q;
        bus.out_id    = out_id_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ext_arbiter.sv
// ============================================================================
//  Module      : tb_ext_arbiter
//  Description : Directed bench for the round-robin shared extender.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ext_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   passed;

    ext_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    ext_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_req(input int idx, input logic [15:0] imm, input logic [1:0] eop);
        bus.req_imm[idx*16 +: 16] = imm;
        bus.req_eop[idx*2 +: 2]   = eop;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'h1111 * 16'(i), 2'b01);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
        else passed++;
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_ext} !== 35'd0)
            $display("FAIL reset_out: got v=%b id=%0d ext=%h want all zero", bus.out_valid, bus.out_id, bus.out_ext);
        else passed++;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_id} !== 3'b1_00)
            $display("FAIL reset_first_result: got v=%b id=%0d want v=1 id=0", bus.out_valid, bus.out_id);
        else passed++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_drain: got out_valid=%b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_eop();
        logic [31:0] exp_ext [4];
        exp_ext[0] = 32'hFFFF8001;
        exp_ext[1] = 32'h00008001;
        exp_ext[2] = 32'h80010000;
        exp_ext[3] = 32'hFFFE0004;
        bus.out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            bus.req_valid = 4'b0100;
            set_req(2, 16'h8001, 2'(e));
            #1;
            checks++;
            if (bus.req_ready !== 4'b0100) $display("FAIL eop%0d_ready: got %b want 0100", e, bus.req_ready);
            else passed++;
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_ext} !== {1'b1, 2'd2, exp_ext[e]})
                $display("FAIL eop%0d_result: got v=%b id=%0d ext=%h want v=1 id=2 ext=%h",
                         e, bus.out_valid, bus.out_id, bus.out_ext, exp_ext[e]);
            else passed++;
            bus.req_valid = 4'b0000;
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_id;
        logic [3:0]  exp_rdy;
        logic [31:0] exp_ext;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'hA000 | 16'(i), 2'b01);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) $display("FAIL rr_first_ready: got %b want 0001", bus.req_ready);
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_id  = 2'((i - 1) % 4);
            exp_ext = 32'h0000A000 | 32'(exp_id);
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_ext} !== {1'b1, exp_id, exp_ext})
                $display("FAIL rr_result%0d: got v=%b id=%0d ext=%h want v=1 id=%0d ext=%h",
                         i, bus.out_valid, bus.out_id, bus.out_ext, exp_id, exp_ext);
            else passed++;
            if (i < 8) begin
                exp_rdy = 4'(1 << (i % 4));
                checks++;
                if (bus.req_ready !== exp_rdy) $display("FAIL rr_ready%0d: got %b want %b", i, bus.req_ready, exp_rdy);
                else passed++;
            end else begin
                bus.req_valid = 4'b0000;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.req_valid = 4'b0011;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) $display("FAIL bp_ready: got %b want 0001", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_ext, bus.req_ready} !== {1'b1, 2'd0, 32'h0000A000, 4'b0000})
                $display("FAIL bp_hold%0d: got v=%b id=%0d ext=%h rdy=%b want v=1 id=0 ext=0000a000 rdy=0000",
                         c, bus.out_valid, bus.out_id, bus.out_ext, bus.req_ready);
            else passed++;
            if (c < 3) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", bus.req_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_ext} !== {1'b1, 2'd1, 32'h0000A001})
            $display("FAIL bp_reload: got v=%b id=%0d ext=%h want v=1 id=1 ext=0000a001",
                     bus.out_valid, bus.out_id, bus.out_ext);
        else passed++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_drain: got out_valid=%b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_pointer_wrap();
        logic [3:0] valids [4];
        logic [1:0] ids    [4];
        logic [1:0] ptrs   [4];
        valids[0] = 4'b0100; valids[1] = 4'b0010; valids[2] = 4'b1000; valids[3] = 4'b0001;
        ids[0] = 2'd2; ids[1] = 2'd1; ids[2] = 2'd3; ids[3] = 2'd0;
        ptrs[0] = 2'd3; ptrs[1] = 2'd2; ptrs[2] = 2'd0; ptrs[3] = 2'd1;
        bus.out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            bus.req_valid = valids[s];
            #1;
            checks++;
            if (bus.req_ready !== valids[s]) $display("FAIL wrap_ready%0d: got %b want %b", s, bus.req_ready, valids[s]);
            else passed++;
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_id, dut.rr_ptr_q} !== {1'b1, ids[s], ptrs[s]})
                $display("FAIL wrap_step%0d: got v=%b id=%0d ptr=%0d want v=1 id=%0d ptr=%0d",
                         s, bus.out_valid, bus.out_id, dut.rr_ptr_q, ids[s], ptrs[s]);
            else passed++;
            bus.req_valid = 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_id} !== 3'b1_10)
            $display("FAIL mid_pending: got v=%b id=%0d want v=1 id=2", bus.out_valid, bus.out_id);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, dut.rr_ptr_q, bus.req_ready} !== {1'b0, 2'd0, 4'b0000})
            $display("FAIL mid_async: got v=%b ptr=%0d rdy=%b want v=0 ptr=0 rdy=0000",
                     bus.out_valid, dut.rr_ptr_q, bus.req_ready);
        else passed++;
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if ({dut.rr_ptr_q, bus.req_ready} !== {2'd0, 4'b0100})
            $display("FAIL mid_release: got ptr=%0d rdy=%b want ptr=0 rdy=0100", dut.rr_ptr_q, bus.req_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_ext} !== {1'b1, 2'd2, 32'h0000A002})
            $display("FAIL mid_regrant: got v=%b id=%0d ext=%h want v=1 id=2 ext=0000a002",
                     bus.out_valid, bus.out_id, bus.out_ext);
        else passed++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_imm   = '0;
        bus.req_eop   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_eop();
        test_round_robin();
        test_backpressure();
        test_pointer_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
